// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, funct values, ALU codes and class helpers.
// DECODE_M_EXT_EN (optional) enables M-extension decode in decode_stage.
package decode_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam int         ALU_CODE_W = 4;
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_BRANCH = 4'b1000;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  typedef enum logic [3:0] {
    CLS_OP, CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BAD
  } instr_cls_e;

  // All opcode constants end in 2'b11, so a bad length field falls out as CLS_BAD.
  function automatic instr_cls_e classify(input logic [6:0] opc);
    case (opc)
      OPC_OP:     return CLS_OP;
      OPC_OP_IMM: return CLS_OP_IMM;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      default:    return CLS_BAD;
    endcase
  endfunction

  function automatic imm_sel_e imm_sel_of(input instr_cls_e cls);
    case (cls)
      CLS_OP_IMM, CLS_LOAD, CLS_JALR: return IMM_I;
      CLS_STORE:                      return IMM_S;
      CLS_BRANCH:                     return IMM_B;
      CLS_LUI, CLS_AUIPC:             return IMM_U;
      CLS_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of decode_stage.
// MULDIV is present only when DECODE_M_EXT_EN is defined.
interface decode_stage_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) ();
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instr;
  logic [XLEN-1:0]     pc;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [4:0]          rd;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src;
  logic [XLEN-1:0]     imm;
  logic [2:0]          funct3;
  logic                allow_wr;
  logic                mem_rd;
  logic                mem_wr;
  logic                branch;
  logic                jump;
`ifdef DECODE_M_EXT_EN
  logic                muldiv;
`endif
  logic                illegal;

`ifdef DECODE_M_EXT_EN
  modport master (
    output in_valid, instr, pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, alu_op, alu_src, imm,
           funct3, allow_wr, mem_rd, mem_wr, branch, jump, muldiv, illegal
  );
  modport slave (
    input  in_valid, instr, pc, flush, out_ready,
    output in_ready, out_valid, out_pc, rs1, rs2, rd, alu_op, alu_src, imm,
           funct3, allow_wr, mem_rd, mem_wr, branch, jump, muldiv, illegal
  );
`else
  modport master (
    output in_valid, instr, pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, alu_op, alu_src, imm,
           funct3, allow_wr, mem_rd, mem_wr, branch, jump, illegal
  );
  modport slave (
    input  in_valid, instr, pc, flush, out_ready,
    output in_ready, out_valid, out_pc, rs1, rs2, rd, alu_op, alu_src, imm,
           funct3, allow_wr, mem_rd, mem_wr, branch, jump, illegal
  );
`endif
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: picks the RV32I immediate format from the
// instruction class and sign-extends it from INSTR[31] to XLEN.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  instr_cls_e      cls_i,
  output logic [XLEN-1:0] imm_o
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_sel_of(cls_i))
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Signed source, so the size cast replicates bit 31 up to XLEN.
    imm_o = XLEN'(imm32);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, valid/ready-handshaked RV32I decoder between fetch and execute.
// Define DECODE_M_EXT_EN to decode the M extension (OP with funct7=0000001).
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  instr_cls_e          cls;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [ALU_CODE_W-1:0] alu_code;
  logic                bad, wr_cls;
  logic [4:0]          rs1_d;
  logic                alu_src_d, allow_wr_d, mem_rd_d, mem_wr_d, branch_d, jump_d;
  logic [XLEN-1:0]     imm_d;
`ifdef DECODE_M_EXT_EN
  logic                muldiv_d, muldiv_q;
`endif

  logic                out_valid_q;
  logic [XLEN-1:0]     pc_q, imm_q;
  logic [4:0]          rs1_q, rs2_q, rd_q;
  logic [ALU_OP_W-1:0] alu_op_q;
  logic [2:0]          funct3_q;
  logic                alu_src_q, allow_wr_q, mem_rd_q, mem_wr_q, branch_q, jump_q, illegal_q;
  logic                accept;

  decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (bus.instr),
    .cls_i   (cls),
    .imm_o   (imm_d)
  );

  always_comb begin
    cls       = classify(bus.instr[6:0]);
    f3        = bus.instr[14:12];
    f7        = bus.instr[31:25];
    alu_code  = ALU_ADD;
    bad       = 1'b0;
    wr_cls    = 1'b0;
    rs1_d     = bus.instr[19:15];
    alu_src_d = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    branch_d  = 1'b0;
    jump_d    = 1'b0;
`ifdef DECODE_M_EXT_EN
    muldiv_d  = 1'b0;
`endif
    case (cls)
      CLS_OP: begin
        wr_cls = 1'b1;
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)))
          alu_code = {bus.instr[30], f3};
`ifdef DECODE_M_EXT_EN
        else if (f7 == F7_MULDIV) begin
          muldiv_d = 1'b1;
          alu_code = {1'b0, f3};
        end
`endif
        else
          bad = 1'b1;
      end
      CLS_OP_IMM: begin
        wr_cls    = 1'b1;
        alu_src_d = 1'b1;
        // Only the shift-right pair carries a qualifier bit in the immediate.
        alu_code  = {(f3 == F3_SRL_SRA) ? bus.instr[30] : 1'b0, f3};
        if (f3 == F3_SLL && f7 != F7_BASE)
          bad = 1'b1;
        if (f3 == F3_SRL_SRA && f7 != F7_BASE && f7 != F7_ALT)
          bad = 1'b1;
      end
      CLS_LOAD: begin
        wr_cls    = 1'b1;
        mem_rd_d  = 1'b1;
        alu_src_d = 1'b1;
      end
      CLS_STORE: begin
        mem_wr_d  = 1'b1;
        alu_src_d = 1'b1;
      end
      CLS_BRANCH: begin
        branch_d = 1'b1;
        alu_code = ALU_BRANCH;
      end
      CLS_LUI: begin
        wr_cls    = 1'b1;
        rs1_d     = '0;
        alu_src_d = 1'b1;
      end
      CLS_AUIPC: begin
        wr_cls    = 1'b1;
        alu_src_d = 1'b1;
      end
      CLS_JAL: begin
        wr_cls = 1'b1;
        jump_d = 1'b1;
      end
      CLS_JALR: begin
        wr_cls    = 1'b1;
        jump_d    = 1'b1;
        alu_src_d = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    // Illegal instructions still travel down the pipe but must have no side effects.
    if (bad) begin
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      branch_d = 1'b0;
      jump_d   = 1'b0;
`ifdef DECODE_M_EXT_EN
      muldiv_d = 1'b0;
`endif
    end
    allow_wr_d = wr_cls && (bus.instr[11:7] != 5'd0) && !bad;
  end

  assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      imm_q       <= '0;
      funct3_q    <= '0;
      allow_wr_q  <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
`ifdef DECODE_M_EXT_EN
      muldiv_q    <= 1'b0;
`endif
      illegal_q   <= 1'b0;
    end else begin
      if (bus.flush)
        out_valid_q <= 1'b0;
      else if (accept)
        out_valid_q <= 1'b1;
      else if (bus.out_ready)
        out_valid_q <= 1'b0;
      if (accept) begin
        pc_q       <= bus.pc;
        rs1_q      <= rs1_d;
        rs2_q      <= bus.instr[24:20];
        rd_q       <= bus.instr[11:7];
        alu_op_q   <= ALU_OP_W'(alu_code);
        alu_src_q  <= alu_src_d;
        imm_q      <= imm_d;
        funct3_q   <= f3;
        allow_wr_q <= allow_wr_d;
        mem_rd_q   <= mem_rd_d;
        mem_wr_q   <= mem_wr_d;
        branch_q   <= branch_d;
        jump_q     <= jump_d;
`ifdef DECODE_M_EXT_EN
        muldiv_q   <= muldiv_d;
`endif
        illegal_q  <= bad;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = pc_q;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;
  assign bus.rd        = rd_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_src   = alu_src_q;
  assign bus.imm       = imm_q;
  assign bus.funct3    = funct3_q;
  assign bus.allow_wr  = allow_wr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.branch    = branch_q;
  assign bus.jump      = jump_q;
`ifdef DECODE_M_EXT_EN
  assign bus.muldiv    = muldiv_q;
`endif
  assign bus.illegal   = illegal_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked RV32I instruction decoder for the pipelined CPU. It sits between the fetch stage and the register-read/execute stage. Relative to the single-cycle decoder, it is parametrised in data width and covers all base opcode classes. It adds sign-extended immediates, illegal-instruction detection, valid/ready flow control, pipeline flush, and optional M-extension decode.

## Interface
- XLEN, 32: datapath width for IMM and PC; must be at least 32.
- ALU_OP_W, 4: ALU operation code width; fixed encoding {qualifier, funct3}.
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  fetch presents an instruction.
- IN_READY  out  1  stage can accept; equals !RST && (!OUT_VALID || OUT_READY) && !FLUSH.
- INSTR  in  32  instruction word.
- PC  in  XLEN  address of INSTR.
- FLUSH  in  1  discard held and incoming instruction.
- OUT_VALID  out  1  decoded bundle valid.
- OUT_READY  in  1  execute accepts the bundle.
- OUT_PC  out  XLEN  registered PC.
- RS1, RS2, RD  out  5 each  register indices.
- ALU_OP  out  ALU_OP_W  ALU operation.
- ALU_SRC  out  1  1 selects IMM as operand B.
- IMM  out  XLEN  sign-extended immediate.
- FUNCT3  out  3  raw funct3, used for branch and load/store size.
- ALLOW_WR  out  1  register-file write enable.
- MEM_RD, MEM_WR, BRANCH, JUMP  out  1 each  control flags.
- MULDIV  out  1  M-extension operation; only present when DECODE_M_EXT_EN is defined.
- ILLEGAL  out  1  undecodable instruction.

## Operation
- **Transfer rule.** An instruction is accepted when IN_VALID && IN_READY. The decoded bundle is registered on that edge, and OUT_VALID goes to 1.
- **OUT_VALID update.** OUT_VALID clears on an edge with OUT_READY && !(IN_VALID && IN_READY). Otherwise it holds.
- **Stall.** While OUT_VALID && !OUT_READY, every output is frozen.
- **Opcode classes:**
  - OP (0110011): ALU_SRC=0; ALU_OP={INSTR[30], funct3}; funct7 must be 0000000, or 0100000 only with funct3 000/101.
  - OP-IMM (0010011): ALU_SRC=1; I-immediate; ALU_OP[3]=INSTR[30] only for funct3=101, else 0.
    - funct3=001 requires INSTR[31:25]=0.
    - funct3=101 requires INSTR[31:25] to be 0000000 or 0100000.
  - LOAD (0000011): MEM_RD=1; ALU_SRC=1; ALU_OP=0000; I-immediate.
  - STORE (0100011): MEM_WR=1; ALLOW_WR=0; ALU_SRC=1; S-immediate.
  - BRANCH (1100011): BRANCH=1; ALLOW_WR=0; ALU_SRC=0; ALU_OP=1000; B-immediate.
  - LUI (0110111): RS1 forced 0; ALU_SRC=1; ALU_OP=0000; U-immediate.
  - AUIPC (0010111): ALU_SRC=1; ALU_OP=0000; U-immediate.
  - JAL (1101111): JUMP=1; J-immediate.
  - JALR (1100111): JUMP=1; ALU_SRC=1; I-immediate.
- **Immediates.** Each is sign-extended from INSTR[31] to XLEN. B and J immediates have bit 0 = 0. U immediate is {INSTR[31:12], 12'b0} sign-extended.
- **Register writes.** ALLOW_WR=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR, but only when RD != 0.
- **Illegal instructions.** ILLEGAL=1 for an unknown opcode, INSTR[1:0] != 11, or a bad funct field. An illegal instruction still transfers with OUT_VALID=1, but ALLOW_WR, MEM_RD, MEM_WR, BRANCH, JUMP and MULDIV are all 0.
- **Flush.** FLUSH=1 clears OUT_VALID at the next edge and accepts nothing that cycle. Flush overrides both a stall and a concurrent transfer.
- **Reset.** Every registered output is 0 after reset, and IN_READY is 0 while RST=1. Reset asserted mid-stall drops the held bundle.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible after edge N.
- Throughput is 1 instruction per cycle when OUT_READY=1.
- IN_READY is combinational from OUT_VALID, OUT_READY, FLUSH and RST. There is no combinational path from INSTR to any output.
- Back-to-back transfers with OUT_READY held high produce no bubble.

## Configuration
- DECODE_M_EXT_EN defined:
  - OP with funct7=0000001 is legal: MULDIV=1, ALU_OP={0, funct3}, ALLOW_WR as for OP.
  - MULDIV reset value is 0.
- DECODE_M_EXT_EN undefined: the MULDIV port and its register are absent, and funct7=0000001 sets ILLEGAL=1.

## Structure
- Opcode constants, ALU_OP codes and funct7 values are added to the shared defs.v package. No local literals.
- imm_gen is a combinational sub-module: it takes INSTR and the instruction class and returns the XLEN immediate.
- Class decode and the output register stay in decode_stage.

## Test plan
- 0x002081B3 (add x3,x1,x2), OUT_READY=1 → next cycle RS1=1, RS2=2, RD=3, ALU_OP=0000, ALU_SRC=0, ALLOW_WR=1, ILLEGAL=0.
- 0xFFF00293 (addi x5,x0,-1) → IMM=0xFFFFFFFF, ALU_SRC=1, ALU_OP=0000. Then 0x4030D093 (srai x1,x1,3) → ALU_OP=1101, IMM[4:0]=3.
- 0xFE208EE3 (beq x1,x2,-4) → BRANCH=1, IMM=0xFFFFFFFC, ALLOW_WR=0, FUNCT3=000.
- Stall: bundle valid, OUT_READY=0 for 3 cycles, new INSTR offered → IN_READY=0 and outputs unchanged for all 3 cycles. OUT_READY=1 → new bundle on the following edge.
- 0x022081B3 (mul x3,x1,x2):
  - With DECODE_M_EXT_EN defined → MULDIV=1, ALU_OP=0000.
  - Without it → ILLEGAL=1, ALLOW_WR=0.
  - 0x00000000 → ILLEGAL=1 in both configurations.
- FLUSH=1 during a stall with IN_VALID=1 → OUT_VALID=0 next cycle and the offered instruction is not accepted. RST=1 mid-stream → all outputs 0 and IN_READY=0.
